// File: rtl/alu_input_loader_if.sv
// Switch/button inputs and registered ALU operands of the ALU input loader.
interface alu_input_loader_if #(
  parameter int NB_DATA = 4,
  parameter int NB_OP   = 6,
  parameter int NB_SW   = 8
);
  logic [NB_SW-1:0]   i_sw;
  logic [2:0]         i_btn;
  logic [NB_DATA-1:0] o_datoA;
  logic [NB_DATA-1:0] o_datoB;
  logic [NB_OP-1:0]   o_operation;
  logic               o_ready;
  logic               o_op_err;
  logic [2:0]         o_load_strobe;

  modport master (
    output i_sw, i_btn,
    input  o_datoA, o_datoB, o_operation, o_ready, o_op_err, o_load_strobe
  );

  modport slave (
    input  i_sw, i_btn,
    output o_datoA, o_datoB, o_operation, o_ready, o_op_err, o_load_strobe
  );
endinterface

// File: rtl/alu_input_loader.sv
// Synchronises switches and buttons, debounces each button and loads the
// ALU operands / opcode on debounced rising edges, rejecting unsupported opcodes.
module alu_input_loader_debounce #(
  parameter int DEBOUNCE_CYCLES = 1000000
) (
  input  logic clk,
  input  logic i_reset,
  input  logic i_sample,
  input  logic i_sync_vld,
  output logic o_rise
);
  localparam int CW = $clog2(DEBOUNCE_CYCLES);
  localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

  logic [CW-1:0] cnt_q, cnt_d;
  logic deb_q, deb_d, prev_q, prev_d, arm_q, arm_d;

  always_ff @(posedge clk or posedge i_reset) begin
    if (i_reset) begin
      cnt_q  <= '0;
      deb_q  <= 1'b0;
      prev_q <= 1'b0;
      arm_q  <= 1'b0;
    end else begin
      cnt_q  <= cnt_d;
      deb_q  <= deb_d;
      prev_q <= prev_d;
      arm_q  <= arm_d;
    end
  end

  always_comb begin
    cnt_d  = cnt_q;
    deb_d  = deb_q;
    prev_d = deb_q;
    if (i_sample == deb_q) begin
      cnt_d = '0;
    end else if (cnt_q == CNT_LAST) begin
      deb_d = ~deb_q;
      cnt_d = '0;
    end else begin
      cnt_d = cnt_q + CW'(1);
    end
    // A button held through reset must be seen released before it may load again.
    arm_d  = arm_q | (i_sync_vld & ~i_sample);
    o_rise = deb_q & ~prev_q & arm_q;
  end
endmodule

module alu_input_loader #(
  parameter int NB_DATA         = 4,
  parameter int NB_OP           = 6,
  parameter int NB_SW           = 8,
  parameter int DEBOUNCE_CYCLES = 1000000
) (
  input logic               clk,
  input logic               i_reset,
  alu_input_loader_if.slave bus
);
  localparam logic [NB_OP-1:0] OP_ADD = NB_OP'(6'b100000);

  logic [NB_SW-1:0]   sw_s1_q, sw_s1_d, sw_s2_q, sw_s2_d;
  logic [2:0]         btn_s1_q, btn_s1_d, btn_s2_q, btn_s2_d;
  logic [1:0]         vld_pipe_q, vld_pipe_d;
  logic [2:0]         rise;
  logic [NB_DATA-1:0] dato_a_q, dato_a_d, dato_b_q, dato_b_d;
  logic [NB_OP-1:0]   op_q, op_d;
  logic               err_q, err_d, ready_q, ready_d, op_ok;
  logic [2:0]         strobe_q, strobe_d, flags_q, flags_d;
  logic               unused_sw;

  function automatic logic op_supported(input logic [NB_OP-1:0] op);
    case (op)
      NB_OP'(6'b100000), NB_OP'(6'b100010), NB_OP'(6'b100100), NB_OP'(6'b100101),
      NB_OP'(6'b100110), NB_OP'(6'b000011), NB_OP'(6'b000010), NB_OP'(6'b100111):
        op_supported = 1'b1;
      default: op_supported = 1'b0;
    endcase
  endfunction

  always_ff @(posedge clk or posedge i_reset) begin
    if (i_reset) begin
      sw_s1_q    <= '0;
      sw_s2_q    <= '0;
      btn_s1_q   <= '0;
      btn_s2_q   <= '0;
      vld_pipe_q <= '0;
      dato_a_q   <= '0;
      dato_b_q   <= '0;
      op_q       <= OP_ADD;
      err_q      <= 1'b0;
      ready_q    <= 1'b0;
      strobe_q   <= '0;
      flags_q    <= '0;
    end else begin
      sw_s1_q    <= sw_s1_d;
      sw_s2_q    <= sw_s2_d;
      btn_s1_q   <= btn_s1_d;
      btn_s2_q   <= btn_s2_d;
      vld_pipe_q <= vld_pipe_d;
      dato_a_q   <= dato_a_d;
      dato_b_q   <= dato_b_d;
      op_q       <= op_d;
      err_q      <= err_d;
      ready_q    <= ready_d;
      strobe_q   <= strobe_d;
      flags_q    <= flags_d;
    end
  end

  // vld_pipe marks when stage 2 holds a real post-reset sample.
  always_comb begin
    sw_s1_d    = bus.i_sw;
    sw_s2_d    = sw_s1_q;
    btn_s1_d   = bus.i_btn;
    btn_s2_d   = btn_s1_q;
    vld_pipe_d = {vld_pipe_q[0], 1'b1};
  end

  genvar gi;
  generate
    for (gi = 0; gi < 3; gi++) begin : g_btn
      alu_input_loader_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db (
        .clk        (clk),
        .i_reset    (i_reset),
        .i_sample   (btn_s2_q[gi]),
        .i_sync_vld (vld_pipe_q[1]),
        .o_rise     (rise[gi])
      );
    end
  endgenerate

  always_comb begin
    op_ok    = op_supported(sw_s2_q[NB_OP-1:0]);
    dato_a_d = rise[0] ? sw_s2_q[NB_DATA-1:0] : dato_a_q;
    dato_b_d = rise[1] ? sw_s2_q[NB_DATA-1:0] : dato_b_q;
    op_d     = op_q;
    err_d    = err_q;
    if (rise[2]) begin
      if (op_ok) begin
        op_d  = sw_s2_q[NB_OP-1:0];
        err_d = 1'b0;
      end else begin
        err_d = 1'b1;
      end
    end
    strobe_d = {rise[2] & op_ok, rise[1], rise[0]};
    flags_d  = flags_q | strobe_d;
    ready_d  = &flags_d;
  end

  assign unused_sw = ^sw_s2_q;

  assign bus.o_datoA       = dato_a_q;
  assign bus.o_datoB       = dato_b_q;
  assign bus.o_operation   = op_q;
  assign bus.o_ready       = ready_q;
  assign bus.o_op_err      = err_q;
  assign bus.o_load_strobe = strobe_q;
endmodule

// File: tb/tb_alu_input_loader.sv
// Scoreboard bench for alu_input_loader with a short debounce window.
module tb_alu_input_loader;
  localparam int DB = 4;
  localparam logic [5:0] OP_ADD = 6'b100000;

  typedef struct packed {
    logic [2:0] strobe;
    logic [3:0] a;
    logic [3:0] b;
    logic [5:0] op;
  } exp_t;

  logic clk = 1'b0;
  logic i_reset = 1'b0;
  always #5 clk = ~clk;

  alu_input_loader_if #(.NB_DATA(4), .NB_OP(6), .NB_SW(8)) bus ();

  alu_input_loader #(.NB_DATA(4), .NB_OP(6), .NB_SW(8), .DEBOUNCE_CYCLES(DB)) dut (
    .clk     (clk),
    .i_reset (i_reset),
    .bus     (bus)
  );

  exp_t       sb_q[$];
  exp_t       sb_e;
  int         total = 0;
  int         bad = 0;
  int         strobe_cnt = 0;
  logic       mon_en = 1'b0;
  logic [3:0] exp_a, exp_b;
  logic [5:0] exp_op;

  // Every strobe must match the oldest expected load.
  always @(negedge clk) begin
    if (mon_en && !i_reset && bus.o_load_strobe != 3'b000) begin
      strobe_cnt++;
      total++;
      if (sb_q.size() == 0) begin
        bad++;
        $display("FAIL unexpected_strobe got=%b want=none", bus.o_load_strobe);
      end else begin
        sb_e = sb_q.pop_front();
        if ({bus.o_load_strobe, bus.o_datoA, bus.o_datoB, bus.o_operation} !== sb_e) begin
          bad++;
          $display("FAIL load_result got=%b/%h/%h/%b want=%b/%h/%h/%b",
                   bus.o_load_strobe, bus.o_datoA, bus.o_datoB, bus.o_operation,
                   sb_e.strobe, sb_e.a, sb_e.b, sb_e.op);
        end
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog got=timeout want=finish");
    $fatal(1, "watchdog");
  end

  task automatic reset_dut();
    @(negedge clk);
    i_reset = 1'b1;
    @(negedge clk);
    i_reset = 1'b0;
    exp_a = 4'h0; exp_b = 4'h0; exp_op = OP_ADD;
    repeat (4) @(negedge clk);
  endtask

  task automatic press(input logic [2:0] mask, input int hold);
    @(negedge clk);
    bus.i_btn = mask;
    repeat (hold) @(negedge clk);
    bus.i_btn = 3'b000;
    repeat (10) @(negedge clk);
  endtask

  task automatic test_reset();
    bus.i_sw = 8'h00; bus.i_btn = 3'b000;
    @(posedge clk);
    #3 i_reset = 1'b1;
    #1;
    total++; if (bus.o_datoA !== 4'h0) begin bad++; $display("FAIL rst_a got=%h want=0", bus.o_datoA); end
    total++; if (bus.o_datoB !== 4'h0) begin bad++; $display("FAIL rst_b got=%h want=0", bus.o_datoB); end
    total++; if (bus.o_operation !== OP_ADD) begin bad++; $display("FAIL rst_op got=%b want=%b", bus.o_operation, OP_ADD); end
    total++; if ({bus.o_ready, bus.o_op_err, bus.o_load_strobe} !== 5'b0) begin
      bad++; $display("FAIL rst_flags got=%b want=00000", {bus.o_ready, bus.o_op_err, bus.o_load_strobe});
    end
    @(negedge clk); @(negedge clk);
    i_reset = 1'b0;
    exp_a = 4'h0; exp_b = 4'h0; exp_op = OP_ADD;
    mon_en = 1'b1;
    repeat (4) @(negedge clk);
  endtask

  task automatic test_load_a();
    int first = -1;
    int hits = 0;
    bus.i_sw = 8'h35;
    exp_a = 4'h5;
    sb_q.push_back({3'b001, exp_a, exp_b, exp_op});
    @(negedge clk);
    bus.i_btn[0] = 1'b1;
    for (int n = 1; n <= 12; n++) begin
      @(negedge clk);
      if (bus.o_load_strobe[0]) begin hits++; if (first < 0) first = n; end
      if (n == 6) begin
        total++; if (bus.o_datoA !== 4'h0) begin bad++; $display("FAIL a_early got=%h want=0", bus.o_datoA); end
      end
      if (n == 10) bus.i_btn[0] = 1'b0;
    end
    total++; if (first != DB + 3) begin bad++; $display("FAIL a_latency got=%0d want=%0d", first, DB + 3); end
    total++; if (hits != 1) begin bad++; $display("FAIL a_single got=%0d want=1", hits); end
    total++; if (bus.o_datoA !== 4'h5) begin bad++; $display("FAIL a_value got=%h want=5", bus.o_datoA); end
    repeat (10) @(negedge clk);
  endtask

  task automatic test_glitch();
    int c0 = strobe_cnt;
    bus.i_sw = 8'hA7;
    press(3'b010, DB - 1);
    total++; if (strobe_cnt != c0) begin bad++; $display("FAIL glitch_strobe got=%0d want=%0d", strobe_cnt, c0); end
    total++; if (bus.o_datoB !== 4'h0) begin bad++; $display("FAIL glitch_b got=%h want=0", bus.o_datoB); end
  endtask

  task automatic test_bad_op();
    int c0 = strobe_cnt;
    bus.i_sw = 8'h21;
    press(3'b100, 8);
    total++; if (bus.o_op_err !== 1'b1) begin bad++; $display("FAIL bad_err got=%b want=1", bus.o_op_err); end
    total++; if (bus.o_operation !== OP_ADD) begin bad++; $display("FAIL bad_hold got=%b want=%b", bus.o_operation, OP_ADD); end
    total++; if (strobe_cnt != c0) begin bad++; $display("FAIL bad_strobe got=%0d want=%0d", strobe_cnt, c0); end
    bus.i_sw = 8'h26;
    exp_op = 6'b100110;
    sb_q.push_back({3'b100, exp_a, exp_b, exp_op});
    press(3'b100, 8);
    total++; if (bus.o_operation !== 6'b100110) begin bad++; $display("FAIL good_op got=%b want=100110", bus.o_operation); end
    total++; if (bus.o_op_err !== 1'b0) begin bad++; $display("FAIL good_err got=%b want=0", bus.o_op_err); end
    total++; if (strobe_cnt != c0 + 1) begin bad++; $display("FAIL good_strobe got=%0d want=%0d", strobe_cnt, c0 + 1); end
  endtask

  task automatic test_ready();
    logic dropped = 1'b0;
    reset_dut();
    bus.i_sw = 8'h03; exp_a = 4'h3;
    sb_q.push_back({3'b001, exp_a, exp_b, exp_op});
    press(3'b001, 8);
    total++; if (bus.o_ready !== 1'b0) begin bad++; $display("FAIL ready_after_a got=%b want=0", bus.o_ready); end
    bus.i_sw = 8'h09; exp_b = 4'h9;
    sb_q.push_back({3'b010, exp_a, exp_b, exp_op});
    press(3'b010, 8);
    total++; if (bus.o_ready !== 1'b0) begin bad++; $display("FAIL ready_after_b got=%b want=0", bus.o_ready); end
    bus.i_sw = 8'h22; exp_op = 6'b100010;
    sb_q.push_back({3'b100, exp_a, exp_b, exp_op});
    @(negedge clk);
    bus.i_btn[2] = 1'b1;
    for (int n = 1; n <= 8; n++) begin
      @(negedge clk);
      if (n == DB + 2) begin
        total++; if (bus.o_ready !== 1'b0) begin bad++; $display("FAIL ready_early got=%b want=0", bus.o_ready); end
      end
      if (n == DB + 3) begin
        total++; if (bus.o_ready !== 1'b1) begin bad++; $display("FAIL ready_rise got=%b want=1", bus.o_ready); end
      end
    end
    bus.i_btn[2] = 1'b0;
    bus.i_sw = 8'h07; exp_a = 4'h7;
    sb_q.push_back({3'b001, exp_a, exp_b, exp_op});
    @(negedge clk);
    bus.i_btn[0] = 1'b1;
    for (int n = 1; n <= 24; n++) begin
      @(negedge clk);
      if (bus.o_ready !== 1'b1) dropped = 1'b1;
      if (n == 8) bus.i_btn[0] = 1'b0;
    end
    total++; if (dropped !== 1'b0) begin bad++; $display("FAIL ready_hold got=dropped want=steady"); end
    total++; if (bus.o_datoA !== 4'h7) begin bad++; $display("FAIL reload_a got=%h want=7", bus.o_datoA); end
  endtask

  task automatic test_simultaneous();
    int c0 = strobe_cnt;
    bus.i_sw = 8'h0C; exp_a = 4'hC; exp_b = 4'hC;
    sb_q.push_back({3'b011, exp_a, exp_b, exp_op});
    press(3'b011, 8);
    total++; if ({bus.o_datoA, bus.o_datoB} !== 8'hCC) begin bad++; $display("FAIL simul_ab got=%h want=cc", {bus.o_datoA, bus.o_datoB}); end
    total++; if (strobe_cnt != c0 + 1) begin bad++; $display("FAIL simul_edges got=%0d want=%0d", strobe_cnt, c0 + 1); end
  endtask

  task automatic test_reset_mid_debounce();
    int c0 = strobe_cnt;
    bus.i_sw = 8'h27;
    @(negedge clk);
    bus.i_btn[2] = 1'b1;
    repeat (3) @(negedge clk);
    i_reset = 1'b1;
    @(negedge clk);
    i_reset = 1'b0;
    exp_a = 4'h0; exp_b = 4'h0; exp_op = OP_ADD;
    repeat (15) @(negedge clk);
    total++; if (strobe_cnt != c0) begin bad++; $display("FAIL held_strobe got=%0d want=%0d", strobe_cnt, c0); end
    total++; if (bus.o_operation !== OP_ADD) begin bad++; $display("FAIL held_op got=%b want=%b", bus.o_operation, OP_ADD); end
    bus.i_btn[2] = 1'b0;
    repeat (10) @(negedge clk);
    exp_op = 6'b100111;
    sb_q.push_back({3'b100, exp_a, exp_b, exp_op});
    press(3'b100, 8);
    total++; if (bus.o_operation !== 6'b100111) begin bad++; $display("FAIL repress_op got=%b want=100111", bus.o_operation); end
    total++; if (strobe_cnt != c0 + 1) begin bad++; $display("FAIL repress_strobe got=%0d want=%0d", strobe_cnt, c0 + 1); end
  endtask

  initial begin
    test_reset();
    test_load_a();
    test_glitch();
    test_bad_op();
    test_ready();
    test_simultaneous();
    test_reset_mid_debounce();
    repeat (4) @(negedge clk);
    total++;
    if (sb_q.size() != 0) begin bad++; $display("FAIL sb_drain got=%0d want=0", sb_q.size()); end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
